// File: rtl/char_scroll_sequencer_if.sv
// Control and display bundle of the scroll sequencer. The bench or host drives
// run/dir/step_n as master. The sequencer drives code_out/pos/tick as slave.
interface char_scroll_sequencer_if;
  logic       run;
  logic       dir;
  logic       step_n;
  logic [7:0] code_out;
  logic [1:0] pos;
  logic       tick;

  modport master (output run, dir, step_n, input code_out, pos, tick);
  modport slave  (input run, dir, step_n, output code_out, pos, tick);
endinterface

// File: rtl/char_scroll_sequencer.sv
// Rotates the four-character message "dE1 " across HEX3..HEX0. It advances on a
// timed auto-scroll tick, or on a debounced button press while paused.
module char_scroll_sequencer #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  char_scroll_sequencer_if.slave  bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  logic [TW-1:0] tick_cnt_reg;
  logic [DW-1:0] stab_cnt_reg;
  logic          sync1_reg;
  logic          sync2_reg;
  logic          deb_reg;
  logic [1:0]    pos_reg;

  logic tick_w;
  logic deb_flip;
  logic step_evt;
  logic advance;

  assign tick_w   = bus.run && (tick_cnt_reg == TICK_LAST);
  assign deb_flip = (sync2_reg != deb_reg) && (stab_cnt_reg == DEB_LAST);
  // A press is the debounced level falling. A held button never re-triggers.
  assign step_evt = deb_flip && deb_reg;
  assign advance  = tick_w || (step_evt && !bus.run);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= bus.step_n;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      deb_reg      <= 1'b1;
      stab_cnt_reg <= '0;
    end else if (sync2_reg == deb_reg) begin
      stab_cnt_reg <= '0;
    end else if (deb_flip) begin
      deb_reg      <= sync2_reg;
      stab_cnt_reg <= '0;
    end else begin
      stab_cnt_reg <= stab_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      tick_cnt_reg <= '0;
    end else if (!bus.run || tick_cnt_reg == TICK_LAST) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  // Two-bit arithmetic gives the 3->0 and 0->3 wrap for free.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pos_reg <= 2'd0;
    end else if (advance) begin
      pos_reg <= bus.dir ? pos_reg - 2'd1 : pos_reg + 2'd1;
    end
  end

  // Message character i has code i. Field k therefore carries (pos + 3 - k) mod 4.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_field
      assign bus.code_out[2*gi +: 2] = pos_reg + 2'(3 - gi);
    end
  endgenerate

  assign bus.pos  = pos_reg;
  assign bus.tick = tick_w;

endmodule

// File: tb/tb_char_scroll_sequencer.sv
// Directed bench for char_scroll_sequencer. A reference model runs from the input
// history and is compared every cycle, alongside hand-computed literal expectations.
module tb_char_scroll_sequencer;
  localparam int TD = 4;
  localparam int DB = 3;

  logic CLOCK_50 = 1'b0;
  logic resetn;
  char_scroll_sequencer_if bus ();

  char_scroll_sequencer #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: message table, edge history of the button, run-length stability.
  int msg [4] = '{0, 1, 2, 3};
  int m_pos = 0;
  int m_run_edges = 0;
  bit m_deb = 1'b1;
  int m_diff_run = 0;
  bit samp [$] = '{1'b1, 1'b1};
  int m_adv = 0;

  function automatic logic [7:0] exp_code(input int p);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[2*k +: 2] = 2'(msg[(p + 3 - k) % 4]);
    return r;
  endfunction

  always @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      m_pos = 0; m_run_edges = 0; m_deb = 1'b1; m_diff_run = 0;
      samp = '{1'b1, 1'b1};
    end else begin
      bit sv, press, tk;
      sv = samp[0];
      press = 1'b0;
      if (sv != m_deb) begin
        m_diff_run++;
        if (m_diff_run == DB) begin
          press = m_deb;
          m_deb = sv;
          m_diff_run = 0;
        end
      end else begin
        m_diff_run = 0;
      end
      tk = bus.run && (m_run_edges % TD == TD - 1);
      if (tk || (press && !bus.run)) begin
        m_pos = bus.dir ? (m_pos + 3) % 4 : (m_pos + 1) % 4;
        m_adv++;
      end
      m_run_edges = bus.run ? m_run_edges + 1 : 0;
      samp.push_back(bus.step_n);
      void'(samp.pop_front());
    end
  end

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      bit et;
      et = resetn && bus.run && (m_run_edges % TD == TD - 1);
      chk("cyc_code", bus.code_out, exp_code(m_pos));
      chk("cyc_pos", {6'd0, bus.pos}, 8'(m_pos));
      chk("cyc_tick", {7'd0, bus.tick}, {7'd0, et});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    int adv0;
    resetn = 1'b1; bus.run = 1'b0; bus.dir = 1'b0; bus.step_n = 1'b1;
    #1 resetn = 1'b0;
    step(1);
    chk_en = 1'b1;
    step(2);
    chk("rst_code", bus.code_out, 8'h1B);
    chk("rst_tick", {7'd0, bus.tick}, 8'h00);

    // Auto-scroll left
    resetn = 1'b1; bus.run = 1'b1;
    step(4);  chk("auto1", bus.code_out, 8'h6C);
    step(4);  chk("auto2", bus.code_out, 8'hB1);
    step(4);  chk("auto3", bus.code_out, 8'hC6);
    step(4);  chk("auto4", bus.code_out, 8'h1B);

    // Scroll right
    bus.dir = 1'b1;
    step(4);  chk("dir1", bus.code_out, 8'hC6);
    step(4);  chk("dir2", bus.code_out, 8'hB1);
    step(4);  chk("dir3", bus.code_out, 8'h6C);
    step(4);  chk("dir4", bus.code_out, 8'h1B);

    // Bounce rejection while paused
    bus.run = 1'b0; bus.dir = 1'b0;
    adv0 = m_adv;
    for (int i = 0; i < 10; i++) begin
      bus.step_n = ~bus.step_n;
      step(1);
    end
    chk("bounce_none", {6'd0, bus.pos}, 8'h00);
    bus.step_n = 1'b0; step(8);
    bus.step_n = 1'b1; step(10);
    chk("bounce_pos", {6'd0, bus.pos}, 8'h01);
    chk("bounce_adv", 8'(m_adv - adv0), 8'd1);

    // Long hold gives exactly one step
    bus.step_n = 1'b0; step(50);
    bus.step_n = 1'b1; step(10);
    chk("hold_pos", {6'd0, bus.pos}, 8'h02);

    // Press while running is ignored, ticks keep cadence (34 edges -> 8 ticks)
    bus.run = 1'b1;
    bus.step_n = 1'b0; step(20);
    bus.step_n = 1'b1; step(14);
    chk("runpress_pos", {6'd0, bus.pos}, 8'h02);

    // Reset mid-count applies without a clock edge
    #1 resetn = 1'b0;
    #1 chk("arst_code", bus.code_out, 8'h1B);
    chk("arst_pos", {6'd0, bus.pos}, 8'h00);
    #3 resetn = 1'b1;
    step(3);
    chk("postrst_tick", {7'd0, bus.tick}, 8'h01);
    chk("postrst_pos0", {6'd0, bus.pos}, 8'h00);
    step(1);
    chk("postrst_pos1", {6'd0, bus.pos}, 8'h01);

    // Pause at count 2, resume 5 cycles later
    step(2);
    bus.run = 1'b0; step(5);
    chk("pause_pos", {6'd0, bus.pos}, 8'h01);
    bus.run = 1'b1; step(3);
    chk("resume_tick", {7'd0, bus.tick}, 8'h01);
    chk("resume_pos0", {6'd0, bus.pos}, 8'h01);
    step(1);
    chk("resume_pos1", {6'd0, bus.pos}, 8'h02);
    step(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/char_scroll_sequencer.md
CHAR_SCROLL_SEQUENCER -- requirements
Module: char_scroll_sequencer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, meaning clock cycles per auto-scroll step (1 Hz at 50 MHz); legal range 2 and up.
REQ-002 The block SHALL have parameter DEB_CYCLES, default 500000, meaning consecutive stable cycles needed to accept a step_n level change (10 ms); legal range 1 and up.
REQ-003 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level input, from a slide switch: 1 = auto-scroll, 0 = paused / manual step.
REQ-006 dir  input  1  level input: 0 = scroll left (pos increments), 1 = scroll right (pos decrements).
REQ-007 step_n  input  1  raw active-low pushbutton, asynchronous to CLOCK_50.
REQ-008 code_out  output  8  four 2-bit character codes: [7:6] = HEX3 (leftmost) through [1:0] = HEX0; each field feeds one downstream 2-bit character decoder.
REQ-009 pos  output  2  current rotation offset.
REQ-010 tick  output  1  single-cycle pulse marking an auto-scroll step.

Function
REQ-011 Character codes SHALL be: 00 = 'd', 01 = 'E', 10 = '1', 11 = blank.
REQ-012 The message SHALL be M[0..3] = 00, 01, 10, 11 ("dE1 ").
REQ-013 Display field k (k = 3 for HEX3 down to k = 0 for HEX0) SHALL carry M[(pos + 3 - k) mod 4].
REQ-014 code_out SHALL be derived from the pos register with no added latency: pos=0 gives 8'h1B, pos=1 gives 8'h6C, pos=2 gives 8'hB1, pos=3 gives 8'hC6.
REQ-015 tick_cnt SHALL be an internal counter of ceil(log2(TICK_DIV)) bits.
REQ-016 While run=1, tick_cnt SHALL count 0 to TICK_DIV-1 and then wrap to 0.
REQ-017 While run=0, tick_cnt SHALL be held at 0.
REQ-018 tick SHALL be combinational: high only when run=1 and tick_cnt = TICK_DIV-1.
REQ-019 step_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-020 The debouncer SHALL hold a debounced level deb and a stability counter.
REQ-021 When the synchronized value differs from deb, the stability counter SHALL increment each cycle.
REQ-022 When that counter reaches DEB_CYCLES-1 while the values still differ, deb SHALL take the synchronized value and the counter SHALL clear.
REQ-023 Whenever the synchronized value equals deb, the stability counter SHALL clear.
REQ-024 A press SHALL be a deb transition from 1 to 0; each press SHALL produce exactly one internal step event, regardless of how long the button is held.
REQ-025 An advance SHALL occur on the clock edge where tick=1, or where a step event occurs while run=0.
REQ-026 A step event while run=1 SHALL be discarded and not queued.
REQ-027 On an advance, pos SHALL become pos+1 mod 4 if dir=0, or pos-1 mod 4 if dir=1.
REQ-028 pos SHALL wrap 3 to 0 and 0 to 3.
REQ-029 At most one advance SHALL occur per cycle.
REQ-030 The new pos and code_out SHALL be visible in the cycle after tick or the step event.
REQ-031 dir SHALL be sampled only at the advance edge; a dir change between advances SHALL have no other effect.
REQ-032 A run transition 1 to 0 SHALL clear tick_cnt on the next edge.
REQ-033 A run transition 0 to 1 SHALL start counting from 0, so the first tick arrives TICK_DIV cycles later.

Reset
REQ-034 While resetn=0, the block SHALL immediately hold pos=0, code_out=8'h1B, tick=0, tick_cnt=0 and the stability counter at 0.
REQ-035 While resetn=0, both synchronizer flops and deb SHALL be 1 (released).
REQ-036 A reset asserted mid-count or mid-debounce SHALL abandon that operation; after reset no step event SHALL be generated unless a fresh press is debounced.
REQ-037 The first advance after resetn rises SHALL be no earlier than TICK_DIV cycles later (run=1) or DEB_CYCLES+2 cycles after a press (run=0).

Verification (TICK_DIV=4, DEB_CYCLES=3)
REQ-038 Scenario, auto-scroll: after reset, run=1 and dir=0 for 16 cycles -> tick pulses every 4th cycle; code_out steps 1B, 6C, B1, C6, 1B.
REQ-039 Scenario, direction: run=1, dir=1 from pos=0 -> pos goes 3, 2, 1, 0; code_out goes C6, B1, 6C, 1B.
REQ-040 Scenario, bounce rejection: run=0, step_n toggles every cycle for 10 cycles, then held low 8 cycles, then held high -> exactly one advance; pos 0 to 1.
REQ-041 Scenario, held button and run override: run=0, step_n held low 50 cycles -> one advance; repeating that press with run=1 -> no step-driven advance, tick cadence unchanged.
REQ-042 Scenario, reset mid-operation: resetn pulsed low mid-count with pos=2 -> code_out=1B immediately without a clock edge; next tick 4 cycles after resetn rises.
REQ-043 Scenario, pause/resume: run dropped at tick_cnt=2, then raised 5 cycles later -> no tick while paused; first tick exactly 4 cycles after run rises.
